// File: rtl/game_pkg.sv
// Shared types and helpers for the game sequencer: phase enum and width math.
package game_pkg;

  // Game phase; encodings are visible on o_state so they are fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    FAIL  = 3'd3,
    WIN   = 3'd4
  } game_state_t;

  localparam int unsigned STATE_W = 3;

  // Number of bits needed to hold values 0..v, never less than one.
  function automatic int unsigned bits_for(input int unsigned v);
    bits_for = 32'd1;
    for (int i = 1; i < 32; i++) begin
      if ((v >> i) != 32'd0) begin
        bits_for = 32'(i + 1);
      end else begin
        bits_for = bits_for;
      end
    end
  endfunction

endpackage

// File: rtl/game_sequencer_rise_detect.sv
// Rising-edge detector with a one-cycle history register. While reset or
// restart is active the edge output is suppressed and the history simply
// takes the live level, so a button held through restart never fires.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic in_i,
  output logic rise_o
);

  logic hist_q;

  // History tracks the input every cycle, including during reset/restart.
  always_ff @(posedge clk) begin
    hist_q <= in_i;
  end

  assign rise_o = in_i & ~hist_q & rst_n & ~load_i;

endmodule

// File: rtl/game_sequencer.sv
// Game tick scheduler and phase controller: turns vsync frames into ticks at
// a selectable speed, buffers one tick until snake and apple are ready, and
// tracks game phase and score.
module game_sequencer
  import game_pkg::*;
#(
  parameter int PERIOD_BASE = 16,
  parameter int SPEED_MAX   = 15,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_restart,
  input  logic               i_pause,
  input  logic               i_start,
  input  logic               i_vsync,
  input  logic               i_speed_up,
  input  logic               i_speed_down,
  input  logic               i_apple_ready,
  input  logic               i_snake_ready,
  input  logic               i_snake_failure,
  input  logic               i_snake_success,
  input  logic               i_eat,
  output logic               o_tick,
  output logic [STATE_W-1:0] o_state,
  output logic               o_failure,
  output logic               o_success,
  output logic               o_paused,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_dropped
);

  localparam int unsigned SPEED_W = bits_for(SPEED_MAX);
  localparam int unsigned CNT_W   = bits_for(PERIOD_BASE);

  game_state_t        state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               pending_q, pending_d;
  logic [SPEED_W-1:0] speed_q,   speed_d;
  logic [SCORE_W-1:0] score_q,   score_d;
  logic               tick_q,    tick_d;
  logic               dropped_q, dropped_d;
  logic               failure_q, success_q, paused_q;

  logic               pause_rise_s, vsync_rise_s, up_rise_s, down_rise_s;
  logic [CNT_W-1:0]   period_s;
  logic               expire_s;
  logic               issue_s;
  logic               in_play_s;

  rise_detect u_rise_pause (.clk(clk), .rst_n(rst_n), .load_i(i_restart), .in_i(i_pause),      .rise_o(pause_rise_s));
  rise_detect u_rise_vsync (.clk(clk), .rst_n(rst_n), .load_i(i_restart), .in_i(i_vsync),      .rise_o(vsync_rise_s));
  rise_detect u_rise_up    (.clk(clk), .rst_n(rst_n), .load_i(i_restart), .in_i(i_speed_up),   .rise_o(up_rise_s));
  rise_detect u_rise_down  (.clk(clk), .rst_n(rst_n), .load_i(i_restart), .in_i(i_speed_down), .rise_o(down_rise_s));

  // Next-state logic for phase, speed, frame counter, pending tick and score.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    speed_d   = speed_q;
    score_d   = score_q;
    tick_d    = 1'b0;
    dropped_d = 1'b0;
    in_play_s = (state_q == RUN) || (state_q == PAUSE);

    // Phase transitions; failure has priority over success, both over pause.
    case (state_q)
      IDLE: begin
        if (i_start) state_d = RUN;
        else         state_d = IDLE;
      end
      RUN: begin
        if      (i_snake_failure) state_d = FAIL;
        else if (i_snake_success) state_d = WIN;
        else if (pause_rise_s)    state_d = PAUSE;
        else                      state_d = RUN;
      end
      PAUSE: begin
        if      (i_snake_failure) state_d = FAIL;
        else if (i_snake_success) state_d = WIN;
        else if (pause_rise_s)    state_d = RUN;
        else                      state_d = PAUSE;
      end
      FAIL:    state_d = FAIL;
      WIN:     state_d = WIN;
      default: state_d = IDLE;
    endcase

    // Speed steps by one per button edge, saturating; opposing edges cancel.
    if (up_rise_s && !down_rise_s) begin
      if (speed_q < SPEED_W'(SPEED_MAX)) speed_d = speed_q + SPEED_W'(1);
      else                               speed_d = speed_q;
    end else if (down_rise_s && !up_rise_s) begin
      if (speed_q != SPEED_W'(0)) speed_d = speed_q - SPEED_W'(1);
      else                        speed_d = speed_q;
    end else begin
      speed_d = speed_q;
    end

    // Tick period in frames, clamped so it never reaches zero.
    period_s = CNT_W'(PERIOD_BASE) - CNT_W'(speed_q);
    if (period_s == CNT_W'(0)) period_s = CNT_W'(1);
    else                       period_s = period_s;

    // Using >= lets a speed-up mid-period expire on the next frame.
    expire_s = (state_q == RUN) && vsync_rise_s && (cnt_q >= (period_s - CNT_W'(1)));
    if (state_q == RUN && vsync_rise_s) begin
      if (expire_s) cnt_d = CNT_W'(0);
      else          cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // A tick goes out only when the world is ready and no game-ending event is in flight.
    issue_s = (state_q == RUN) && pending_q && i_snake_ready && i_apple_ready &&
              !i_snake_failure && !i_snake_success;
    tick_d  = issue_s;

    // One-deep buffer: an expiry with a tick still waiting is reported as dropped.
    if (expire_s) begin
      pending_d = 1'b1;
      dropped_d = pending_q && !issue_s;
    end else if (issue_s) begin
      pending_d = 1'b0;
      dropped_d = 1'b0;
    end else begin
      pending_d = pending_q;
      dropped_d = 1'b0;
    end

    // Score counts apples during a live game and sticks at all-ones.
    if (i_eat && in_play_s && !(&score_q)) score_d = score_q + SCORE_W'(1);
    else                                   score_d = score_q;
  end

  // State and output registers; restart clears the game but keeps the speed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_W'(0);
      pending_q <= 1'b0;
      speed_q   <= SPEED_W'(0);
      score_q   <= SCORE_W'(0);
      tick_q    <= 1'b0;
      dropped_q <= 1'b0;
      failure_q <= 1'b0;
      success_q <= 1'b0;
      paused_q  <= 1'b0;
    end else if (i_restart) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_W'(0);
      pending_q <= 1'b0;
      speed_q   <= speed_q;
      score_q   <= SCORE_W'(0);
      tick_q    <= 1'b0;
      dropped_q <= 1'b0;
      failure_q <= 1'b0;
      success_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      speed_q   <= speed_d;
      score_q   <= score_d;
      tick_q    <= tick_d;
      dropped_q <= dropped_d;
      failure_q <= (state_d == FAIL);
      success_q <= (state_d == WIN);
      paused_q  <= (state_d == PAUSE);
    end
  end

  assign o_tick    = tick_q;
  assign o_state   = state_q;
  assign o_failure = failure_q;
  assign o_success = success_q;
  assign o_paused  = paused_q;
  assign o_score   = score_q;
  assign o_dropped = dropped_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer with PERIOD_BASE=4, SPEED_MAX=3. Expected
// tick/drop events are queued with their cycle stamps by the stimulus and
// popped by an independent monitor whenever the DUT pulses an output.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, i_restart, i_pause, i_start, i_vsync;
  logic       i_speed_up, i_speed_down, i_apple_ready, i_snake_ready;
  logic       i_snake_failure, i_snake_success, i_eat;
  logic       o_tick, o_failure, o_success, o_paused, o_dropped;
  logic [2:0] o_state;
  logic [7:0] o_score;

  typedef struct {
    int kind;  // 1 = tick, 2 = dropped
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;

  game_sequencer #(.PERIOD_BASE(4), .SPEED_MAX(3), .SCORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_restart(i_restart), .i_pause(i_pause),
    .i_start(i_start), .i_vsync(i_vsync), .i_speed_up(i_speed_up),
    .i_speed_down(i_speed_down), .i_apple_ready(i_apple_ready),
    .i_snake_ready(i_snake_ready), .i_snake_failure(i_snake_failure),
    .i_snake_success(i_snake_success), .i_eat(i_eat), .o_tick(o_tick),
    .o_state(o_state), .o_failure(o_failure), .o_success(o_success),
    .o_paused(o_paused), .o_score(o_score), .o_dropped(o_dropped)
  );

  always #5 clk = ~clk;

  // Cycle stamp: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every tick/drop pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    int  k;
    ev_t e;
    if (o_tick || o_dropped) begin
      k = int'({o_dropped, o_tick});
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got kind=%0d at cyc=%0d, expected no event", k, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc) begin
          fails++;
          $display("FAIL event: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", k, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame: vsync high for one cycle, then three quiet cycles.
  task automatic frame(input bit exp_tick, input bit exp_drop);
    int c;
    @(negedge clk);
    i_vsync = 1'b1;
    c = cyc;
    if (exp_drop) exp_q.push_back('{2, c + 1});
    if (exp_tick) exp_q.push_back('{1, c + 2});
    @(negedge clk);
    i_vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // n frames; a tick is expected on every 'every'-th frame (0 = none).
  task automatic run_frames(input int n, input int every);
    for (int i = 1; i <= n; i++) begin
      frame((every > 0) && (i % every == 0), 1'b0);
    end
  endtask

  task automatic do_restart();
    @(negedge clk); i_restart = 1'b1;
    @(negedge clk); i_restart = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic do_pause();
    @(negedge clk); i_pause = 1'b1;
    @(negedge clk); i_pause = 1'b0;
  endtask

  task automatic do_speed(input bit up, input bit down);
    @(negedge clk); i_speed_up = up; i_speed_down = down;
    @(negedge clk); i_speed_up = 1'b0; i_speed_down = 1'b0;
  endtask

  task automatic do_eat();
    @(negedge clk); i_eat = 1'b1;
    @(negedge clk); i_eat = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_restart = 1'b0; i_pause = 1'b0; i_start = 1'b0;
    i_vsync = 1'b0; i_speed_up = 1'b0; i_speed_down = 1'b0;
    i_apple_ready = 1'b1; i_snake_ready = 1'b1;
    i_snake_failure = 1'b0; i_snake_success = 1'b0; i_eat = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset values
    check("reset_state",   int'(o_state),   0);
    check("reset_failure", int'(o_failure), 0);
    check("reset_success", int'(o_success), 0);
    check("reset_paused",  int'(o_paused),  0);
    check("reset_score",   int'(o_score),   0);

    // Speed 0: tick two cycles after every 4th frame edge, never a drop
    do_start();
    check("start_run", int'(o_state), 1);
    run_frames(8, 4);

    // Snake not ready over two expiries: one drop, then one tick on ready
    do_restart();
    i_snake_ready = 1'b0;
    do_start();
    run_frames(7, 0);
    frame(1'b0, 1'b1);
    @(negedge clk);
    exp_q.push_back('{1, cyc + 1});
    i_snake_ready = 1'b1;
    run_frames(3, 0);

    // Speed saturates at 3: period of one frame; survives restart
    do_restart();
    do_start();
    for (int i = 0; i < 20; i++) do_speed(1'b1, 1'b0);
    run_frames(3, 1);
    do_restart();
    check("restart_idle", int'(o_state), 0);
    do_start();
    run_frames(2, 1);

    // Full reset returns speed to 0; down saturates, opposing edges cancel
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("rstn_state", int'(o_state), 0);
    do_start();
    do_speed(1'b0, 1'b1);
    do_speed(1'b0, 1'b1);
    do_speed(1'b1, 1'b1);
    run_frames(4, 4);

    // Pause in RUN freezes frame counting; second edge resumes
    do_restart();
    do_start();
    run_frames(2, 0);
    do_pause();
    check("pause_state",  int'(o_state),  2);
    check("pause_paused", int'(o_paused), 1);
    run_frames(10, 0);
    do_pause();
    check("resume_state",  int'(o_state),  1);
    check("resume_paused", int'(o_paused), 0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);

    // Pause edge in IDLE is ignored
    do_restart();
    do_pause();
    check("idle_pause_state",  int'(o_state),  0);
    check("idle_pause_paused", int'(o_paused), 0);
    do_start();
    check("idle_pause_then_run", int'(o_state), 1);

    // Simultaneous failure and success: FAIL wins, terminal, no ticks
    do_restart();
    do_start();
    do_eat(); do_eat(); do_eat();
    check("score_3", int'(o_score), 3);
    @(negedge clk); i_snake_failure = 1'b1; i_snake_success = 1'b1;
    @(negedge clk); i_snake_failure = 1'b0; i_snake_success = 1'b0;
    check("fail_state",   int'(o_state),   3);
    check("fail_failure", int'(o_failure), 1);
    check("fail_success", int'(o_success), 0);
    do_pause();
    check("fail_pause_ignored", int'(o_state), 3);
    run_frames(8, 0);
    do_restart();
    check("fail_restart_state", int'(o_state),   0);
    check("fail_restart_score", int'(o_score),   0);
    check("fail_restart_flag",  int'(o_failure), 0);

    // Success alone: WIN; eating no longer scores
    do_start();
    @(negedge clk); i_snake_success = 1'b1;
    @(negedge clk); i_snake_success = 1'b0;
    check("win_state",   int'(o_state),   4);
    check("win_success", int'(o_success), 1);
    do_eat();
    check("win_no_score", int'(o_score), 0);

    // Score saturates at 255 after 300 eats
    do_restart();
    do_start();
    @(negedge clk); i_eat = 1'b1;
    repeat (300) @(negedge clk);
    i_eat = 1'b0;
    check("score_sat", int'(o_score), 255);

    // Restart with pause held: no toggle once the game starts
    @(negedge clk); i_pause = 1'b1; i_restart = 1'b1;
    @(negedge clk); i_restart = 1'b0;
    check("held_pause_idle",  int'(o_state), 0);
    check("held_pause_score", int'(o_score), 0);
    do_start();
    check("held_pause_run", int'(o_state), 1);
    @(negedge clk); i_pause = 1'b0;
    @(negedge clk);
    check("held_pause_release", int'(o_state), 1);

    // Every expected event must have been seen
    repeat (5) @(negedge clk);
    check("events_outstanding", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Central tick scheduler and game-state controller for the snake game top level. Converts VGA vsync frame edges into game ticks at a user-selectable speed, gates each tick on snake and apple readiness, and owns the game-phase state machine (idle, run, pause, fail, win) plus the score counter. It replaces the ad hoc tick gating and sticky failure/success flags in the top level, and drives `i_tick` of the snake datapath.

## Interface
- `PERIOD_BASE`, default 16: frames per tick at speed 0.
- `SPEED_MAX`, default 15: highest speed level; must be less than `PERIOD_BASE`.
- `SCORE_W`, default 8: score counter width.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low; full reset including speed.
- `i_restart`  in  1  synchronous game restart, level; resets everything except speed.
- `i_pause`  in  1  pause button, level; each rising edge toggles pause.
- `i_start`  in  1  first user direction seen (from control).
- `i_vsync`  in  1  frame marker; each rising edge is one frame.
- `i_speed_up`, `i_speed_down`  in  1  buttons, level; each rising edge changes speed by ±1.
- `i_apple_ready`  in  1  apple placement valid.
- `i_snake_ready`  in  1  snake iterator at first segment; a tick may be applied.
- `i_snake_failure`, `i_snake_success`, `i_eat`  in  1  single-cycle event pulses from snake/apple.
- `o_tick`  out  1  single-cycle tick to snake.
- `o_state`  out  3  current `game_state_t`.
- `o_failure`, `o_success`, `o_paused`  out  1  state decodes.
- `o_score`  out  `SCORE_W`  apples eaten this game.
- `o_dropped`  out  1  single-cycle pulse when a tick period expires with a tick still pending.

## Operation
- States: IDLE, RUN, PAUSE, FAIL, WIN.
- Transitions:
  - IDLE→RUN on `i_start`.
  - RUN↔PAUSE on a pause rising edge.
  - RUN or PAUSE → FAIL on `i_snake_failure`.
  - RUN or PAUSE → WIN on `i_snake_success`.
  - If failure and success arrive together, FAIL wins.
  - FAIL and WIN are terminal until restart.
  - Pause edges in IDLE, FAIL or WIN are ignored.
- Speed register, 0..`SPEED_MAX`:
  - Up/down edges saturate at the bounds; both edges in the same cycle cause no change.
  - Active in every state.
- Tick period in frames is `PERIOD_BASE - speed`, minimum 1.
- Frame counter:
  - Counts vsync rising edges only in RUN.
  - When the counter is ≥ period−1 on a frame edge (this covers a speed change mid-period), it clears to 0 and the period expires.
- Pending flag (one-deep buffer):
  - Expiry sets it.
  - If pending is already 1 at expiry and no tick is issued that cycle, pulse `o_dropped`; pending stays 1.
- Tick issue:
  - Condition: state RUN, pending=1, `i_snake_ready`, `i_apple_ready`, and no failure/success input this cycle.
  - Effect: `o_tick`=1 next cycle and pending cleared.
  - Issue and expiry in the same cycle: pending stays 1 and no drop.
- Score:
  - Increments on `i_eat` while in RUN or PAUSE.
  - Saturates at all-ones.
- Restart (`i_restart`=1 or `rst_n`=0):
  - State→IDLE; counter, pending and score are cleared.
  - Edge-detector history loads the current input levels, so a held button does not fire.
  - `rst_n` additionally clears speed to 0.

## Timing
- All outputs are registered.
- Reset values: `o_tick`=0, `o_state`=IDLE, `o_failure`=`o_success`=`o_paused`=0, `o_score`=0, `o_dropped`=0.
- Rising edge detection: input=1 at a clock edge with history=0.
- Latency:
  - Vsync edge sampled at edge N → pending=1 after N.
  - Earliest `o_tick` is high after edge N+1 (2-cycle latency).
- Event latency: a failure or success pulse at edge N → `o_failure`/`o_success` high after N.
- Restart overrides all other events in the same cycle.

## Structure
- `game_pkg`: `game_state_t` enum (IDLE=0, RUN=1, PAUSE=2, FAIL=3, WIN=4), width constants.
- Sub-module `rise_detect` (registered history with synchronous load-on-reset), instantiated for pause, vsync, speed up and speed down.

## Test plan
- Reset, then `i_start`, with `PERIOD_BASE`=4, speed 0, both readies held 1 → `o_tick` fires 2 cycles after every 4th vsync edge; `o_dropped` stays 0.
- Hold `i_snake_ready`=0 across 2 expiries → one `o_dropped` pulse; on ready, exactly one `o_tick`.
- 20 speed-up edges → speed saturates at `SPEED_MAX`=3 (with `PERIOD_BASE`=4) and period=1 frame. `i_restart` keeps speed 3; `rst_n` returns it to 0.
- Pause edge in RUN → PAUSE with no ticks for 10 frames; a second edge resumes. Pause edge in IDLE → stays IDLE.
- `i_snake_failure` and `i_snake_success` in the same cycle → FAIL, `o_success`=0; later vsyncs issue no ticks; `i_restart` → IDLE with score 0.
- `i_eat` 300 times with `SCORE_W`=8 → `o_score`=255. Restart with `i_pause` held high → no pause toggle after `i_start`.
